// File: rtl/sr_set_reset_driver.sv
// sr_set_reset_driver
//   Command-side driver for a bank of N set/reset flops. Each accepted
//   "write value V to channel I" request becomes a PULSE_W-cycle set or
//   reset pulse on that channel's s/r pair. A GAP-cycle quiet period
//   follows each pulse. A shadow copy of every channel's state is kept,
//   and writes that would not change a channel are skipped. The
//   combination s[k]=1,r[k]=1 is never produced. At most one s/r line is
//   high in any cycle.
//
// Optional feature (macro SR_READBACK_CHECK_EN):
//   - Adds the ports q_fb, err and err_idx.
//   - The GAP period is stretched to at least one cycle.
//   - At the edge that ends the first GAP cycle, q_fb[idx] is compared
//     with the value just written.
//   - The first mismatch sets err, which stays set until reset.
//   - The first mismatch also records err_idx. Later mismatches do not
//     change it.
//
// Ports:
//   clk        in   1      clock, rising edge
//   rst        in   1      synchronous active-high reset
//   req_valid  in   1      request present
//   req_ready  out  1      (state==IDLE) & ~rst
//   req_idx    in   IDX_W  target channel
//   req_val    in   1      1 = set, 0 = reset
//   s          out  N      registered set pulses
//   r          out  N      registered reset pulses
//   shadow     out  N      believed state of each channel
//   busy       out  1      high while in PULSE or GAP
//   q_fb       in   N      channel feedback       (SR_READBACK_CHECK_EN only)
//   err        out  1      sticky mismatch flag   (SR_READBACK_CHECK_EN only)
//   err_idx    out  IDX_W  first mismatch channel (SR_READBACK_CHECK_EN only)

module sr_set_reset_driver #(
  parameter int N       = 4,
  parameter int IDX_W   = 2,
  parameter int PULSE_W = 2,
  parameter int GAP     = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [IDX_W-1:0] req_idx,
  input  logic             req_val,
  output logic [N-1:0]     s,
  output logic [N-1:0]     r,
  output logic [N-1:0]     shadow,
`ifdef SR_READBACK_CHECK_EN
  input  logic [N-1:0]     q_fb,
  output logic             err,
  output logic [IDX_W-1:0] err_idx,
`endif
  output logic             busy
);

  // The readback check samples feedback during the GAP period, so GAP
  // must last at least one cycle when the check is built in.
`ifdef SR_READBACK_CHECK_EN
  localparam int GAP_EFF = (GAP < 1) ? 1 : GAP;
`else
  localparam int GAP_EFF = GAP;
`endif

  localparam int CNT_MAX = (PULSE_W > GAP_EFF) ? PULSE_W : GAP_EFF;
  localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [IDX_W-1:0]   idx_reg, idx_next;
  logic               val_reg, val_next;
  logic [N-1:0]       s_reg, s_next;
  logic [N-1:0]       r_reg, r_next;
  logic [N-1:0]       shadow_reg, shadow_next;

  // One-hot decodes of the incoming index and of the latched index.
  // A request whose index decodes to no channel is out of range.
  logic [N-1:0]       sel_req;
  logic [N-1:0]       sel_cur;
  logic               in_range;
  logic               cur_shadow;
  logic               accept;
  logic               start;
  logic               pulse_end;
  logic               gap_end;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_sel
      assign sel_req[gi] = (req_idx == IDX_W'(gi));
      assign sel_cur[gi] = (idx_reg == IDX_W'(gi));
    end
  endgenerate

  assign in_range   = |sel_req;
  assign cur_shadow = |(shadow_reg & sel_req);
  assign accept     = req_valid & req_ready;
  // Only in-range writes that change the channel start a pulse.
  // Dropped and redundant requests complete the handshake and leave the
  // FSM in IDLE.
  assign start      = accept & in_range & (req_val != cur_shadow);
  assign pulse_end  = (state_reg == ST_PULSE) && (cnt_reg == CNT_W'(PULSE_W - 1));
  assign gap_end    = (state_reg == ST_GAP)   && (cnt_reg == CNT_W'(GAP_EFF - 1));

  // ---------------- state register ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---------------- next-state logic ----------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (start) state_next = ST_PULSE;
      end
      ST_PULSE: begin
        if (pulse_end) state_next = (GAP_EFF == 0) ? ST_IDLE : ST_GAP;
      end
      ST_GAP: begin
        if (gap_end) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // ---------------- FSM outputs ----------------
  always_comb begin
    req_ready = (state_reg == ST_IDLE) & ~rst;
    busy      = (state_reg != ST_IDLE) & ~rst;
  end

  // ---------------- datapath next values ----------------
  always_comb begin
    cnt_next = '0;
    idx_next = idx_reg;
    val_next = val_reg;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          idx_next = req_idx;
          val_next = req_val;
        end
      end
      // The counter counts the cycles already spent in the current
      // state. It goes back to zero on every state change.
      ST_PULSE: cnt_next = pulse_end ? '0 : cnt_reg + CNT_W'(1);
      ST_GAP:   cnt_next = gap_end   ? '0 : cnt_reg + CNT_W'(1);
      default:  cnt_next = '0;
    endcase
  end

  // Pulse lines:
  //   - A line is raised on the accept edge.
  //   - It is held through PULSE.
  //   - It is cleared on the edge that ends PULSE.
  // Only the latched channel's line can be high, so s and r never
  // overlap.
  generate
    for (gi = 0; gi < N; gi++) begin : g_chan
      assign s_next[gi] = (start & req_val & sel_req[gi]) |
                          ((state_reg == ST_PULSE) & ~pulse_end & s_reg[gi]);
      assign r_next[gi] = (start & ~req_val & sel_req[gi]) |
                          ((state_reg == ST_PULSE) & ~pulse_end & r_reg[gi]);
      assign shadow_next[gi] = (pulse_end & sel_cur[gi]) ? val_reg : shadow_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg    <= '0;
      idx_reg    <= '0;
      val_reg    <= 1'b0;
      s_reg      <= '0;
      r_reg      <= '0;
      shadow_reg <= '0;
    end else begin
      cnt_reg    <= cnt_next;
      idx_reg    <= idx_next;
      val_reg    <= val_next;
      s_reg      <= s_next;
      r_reg      <= r_next;
      shadow_reg <= shadow_next;
    end
  end

  assign s      = s_reg;
  assign r      = r_reg;
  assign shadow = shadow_reg;

`ifdef SR_READBACK_CHECK_EN
  logic             err_reg, err_next;
  logic [IDX_W-1:0] err_idx_reg, err_idx_next;
  logic             fb_bit;
  logic             check_now;

  assign fb_bit    = |(q_fb & sel_cur);
  // The check happens at the edge that ends the first GAP cycle.
  assign check_now = (state_reg == ST_GAP) && (cnt_reg == '0);

  always_comb begin
    err_next     = err_reg;
    err_idx_next = err_idx_reg;
    if (check_now && (fb_bit != val_reg) && !err_reg) begin
      err_next     = 1'b1;
      err_idx_next = idx_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_reg     <= 1'b0;
      err_idx_reg <= '0;
    end else begin
      err_reg     <= err_next;
      err_idx_reg <= err_idx_next;
    end
  end

  assign err     = err_reg;
  assign err_idx = err_idx_reg;
`endif

endmodule

// File: tb/tb_sr_set_reset_driver.sv
module tb_sr_set_reset_driver;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_idx;
  logic       req_val;
  logic [3:0] s, r, shadow;
  logic       busy;

  // Second instance with N=3 so that an out-of-range index can be sent.
  logic       valid3;
  logic       ready3;
  logic [1:0] idx3;
  logic       val3;
  logic [2:0] s3, r3, shadow3;
  logic       busy3;

`ifdef SR_READBACK_CHECK_EN
  logic [3:0] q_fb  = 4'b0000;
  logic [2:0] q_fb3 = 3'b000;
  logic       err, err3;
  logic [1:0] err_idx, err_idx3;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sr_set_reset_driver #(.N(4), .IDX_W(2), .PULSE_W(2), .GAP(1)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_idx(req_idx), .req_val(req_val), .s(s), .r(r), .shadow(shadow),
`ifdef SR_READBACK_CHECK_EN
    .q_fb(q_fb), .err(err), .err_idx(err_idx),
`endif
    .busy(busy)
  );

  sr_set_reset_driver #(.N(3), .IDX_W(2), .PULSE_W(2), .GAP(1)) dut3 (
    .clk(clk), .rst(rst), .req_valid(valid3), .req_ready(ready3),
    .req_idx(idx3), .req_val(val3), .s(s3), .r(r3), .shadow(shadow3),
`ifdef SR_READBACK_CHECK_EN
    .q_fb(q_fb3), .err(err3), .err_idx(err_idx3),
`endif
    .busy(busy3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and sample 1 time unit after the edge.
  // The s/r invariants are checked on every cycle.
  task automatic tick();
    @(posedge clk);
    #1;
    chk("inv_s_and_r", 32'(s & r), 32'd0);
    chk("inv_onehot", 32'($countones(s | r) <= 1), 32'd1);
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_idx = 2'd0; req_val = 1'b0;
    valid3 = 1'b0; idx3 = 2'd0; val3 = 1'b0;

    // 1. reset for two cycles
    tick();
    chk("rst_s", 32'(s), 32'h0);
    chk("rst_r", 32'(r), 32'h0);
    chk("rst_shadow", 32'(shadow), 32'h0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    tick();
    chk("rst_ready2", 32'(req_ready), 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", 32'(req_ready), 32'd1);
    $display("txn reset done");

    // 2. set channel 2, then send a redundant repeat
    req_valid = 1'b1; req_idx = 2'd2; req_val = 1'b1;
    tick();                       // accept edge T
    req_valid = 1'b0;
    chk("set2_s_t1", 32'(s), 32'h4);
    chk("set2_busy", 32'(busy), 32'd1);
    chk("set2_ready", 32'(req_ready), 32'd0);
    chk("set2_shadow_t1", 32'(shadow), 32'h0);
    tick();                       // T+1
    chk("set2_s_t2", 32'(s), 32'h4);
    tick();                       // T+2: pulse ends, enter GAP
    chk("set2_s_t3", 32'(s), 32'h0);
    chk("set2_shadow", 32'(shadow), 32'h4);
    chk("set2_gap_busy", 32'(busy), 32'd1);
    tick();                       // T+3: back in IDLE
    chk("set2_idle_ready", 32'(req_ready), 32'd1);
    chk("set2_idle_busy", 32'(busy), 32'd0);
    $display("txn set idx=2 val=1 shadow=%b", shadow);
    req_valid = 1'b1; req_idx = 2'd2; req_val = 1'b1;
    tick();                       // redundant request is accepted and skipped
    req_valid = 1'b0;
    chk("redund_s", 32'(s), 32'h0);
    chk("redund_ready", 32'(req_ready), 32'd1);
    chk("redund_busy", 32'(busy), 32'd0);
    chk("redund_shadow", 32'(shadow), 32'h4);
    $display("txn redundant idx=2 val=1 skipped");

    // 3. back-to-back requests to channel 0, valid held high
    req_valid = 1'b1; req_idx = 2'd0; req_val = 1'b1;
    tick();                       // A: first accepted
    req_val = 1'b0;               // second request, still valid
    chk("b2b_s_a0", 32'(s), 32'h1);
    tick();                       // A+1
    chk("b2b_s_a1", 32'(s), 32'h1);
    chk("b2b_ready_a1", 32'(req_ready), 32'd0);
    tick();                       // A+2
    chk("b2b_s_a2", 32'(s), 32'h0);
    chk("b2b_shadow_a2", 32'(shadow), 32'h5);
    chk("b2b_ready_a2", 32'(req_ready), 32'd0);
    tick();                       // A+3: IDLE, second accepted at next edge
    chk("b2b_ready_a3", 32'(req_ready), 32'd1);
    chk("b2b_r_a3", 32'(r), 32'h0);
    tick();                       // A+4 = A + 1 + PULSE_W + GAP
    req_valid = 1'b0;
    chk("b2b_r_a4", 32'(r), 32'h1);
    chk("b2b_s_a4", 32'(s), 32'h0);
    tick();
    chk("b2b_r_a5", 32'(r), 32'h1);
    tick();
    chk("b2b_r_a6", 32'(r), 32'h0);
    chk("b2b_shadow_a6", 32'(shadow), 32'h4);
    tick();
    $display("txn back-to-back idx=0 set/reset shadow=%b", shadow);

    // 4. reset in the second PULSE cycle of a set on channel 1
    req_valid = 1'b1; req_idx = 2'd1; req_val = 1'b1;
    tick();                       // B: accept
    req_valid = 1'b0;
    chk("abort_s_b0", 32'(s), 32'h2);
    tick();                       // B+1: second pulse cycle
    chk("abort_s_b1", 32'(s), 32'h2);
    rst = 1'b1;
    #1;
    chk("abort_ready_rst", 32'(req_ready), 32'd0);
    tick();                       // B+2: reset edge
    chk("abort_s", 32'(s), 32'h0);
    chk("abort_shadow1", 32'(shadow[1]), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    #1;
    chk("abort_idle_ready", 32'(req_ready), 32'd1);
    $display("txn abort idx=1 by reset shadow=%b", shadow);

    // 5. out-of-range index on the N=3 instance
    valid3 = 1'b1; idx3 = 2'd3; val3 = 1'b1;
    #1;
    chk("drop_ready_pre", 32'(ready3), 32'd1);
    tick();
    valid3 = 1'b0;
    chk("drop_s", 32'(s3), 32'h0);
    chk("drop_r", 32'(r3), 32'h0);
    chk("drop_busy", 32'(busy3), 32'd0);
    chk("drop_ready", 32'(ready3), 32'd1);
    tick();
    chk("drop_shadow", 32'(shadow3), 32'h0);
    valid3 = 1'b1; idx3 = 2'd2; val3 = 1'b1;
    tick();
    valid3 = 1'b0;
    chk("n3_set2_s", 32'(s3), 32'h4);
    tick();
    tick();
    chk("n3_set2_shadow", 32'(shadow3), 32'h4);
    tick();
    $display("txn drop idx=3 on N=3, then set idx=2 shadow3=%b", shadow3);

`ifdef SR_READBACK_CHECK_EN
    // 6. readback mismatch with q_fb tied low
    req_valid = 1'b1; req_idx = 2'd1; req_val = 1'b1;
    tick();                       // C: accept
    req_valid = 1'b0;
    tick();                       // C+1
    tick();                       // C+2: enter GAP
    chk("rb_err_pre", 32'(err), 32'd0);
    tick();                       // C+3: first GAP cycle ends
    chk("rb_err", 32'(err), 32'd1);
    chk("rb_err_idx", 32'(err_idx), 32'd1);
    req_valid = 1'b1; req_idx = 2'd1; req_val = 1'b0;
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    tick();
    tick();
    chk("rb_err_sticky", 32'(err), 32'd1);
    chk("rb_err_idx_sticky", 32'(err_idx), 32'd1);
    chk("rb_shadow", 32'(shadow), 32'h0);
    $display("txn readback err=%0d err_idx=%0d", err, err_idx);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
